// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format codes and XLEN legality helper
// Shared by the decoder and the pipelined wrapper.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_IU  = 3'b110;
  localparam logic [2:0] IMM_ILL = 3'b111;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV immediate decoder
// Builds a 32-bit immediate, then sign- or zero-extends it to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] w_raw;
  logic        w_sext;

  always_comb begin
    w_raw  = '0;
    w_sext = 1'b1;
    err    = 1'b0;
    case (src)
      IMM_I:  w_raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  w_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  w_raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:  w_raw = {instr[31:12], 12'b0};
      IMM_J:  w_raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z: begin
        w_raw  = {27'b0, instr[19:15]};
        w_sext = 1'b0;
      end
      IMM_IU: begin
        w_raw  = {20'b0, instr[31:20]};
        w_sext = 1'b0;
      end
      default: begin
        w_raw  = '0;
        w_sext = 1'b0;
        err    = 1'b1;
      end
    endcase
    // Every signed format already carries bit 31 in w_raw[31], so one extension suffices.
    imm = w_sext ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer
// Decode on input, then OUT/SKID registers with valid/ready handshake and flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_err;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .src   (in_src),
    .imm   (w_dec_imm),
    .err   (w_dec_err)
  );

  logic             r_out_valid, r_skid_valid, r_in_ready;
  logic [XLEN-1:0]  r_out_imm, r_skid_imm;
  logic [TAG_W-1:0] r_out_tag, r_skid_tag;
  logic             r_out_err, r_skid_err;

  logic w_accept, w_out_free;
  logic w_out_valid_nxt, w_skid_valid_nxt;
  logic w_load_out_skid, w_load_out_in, w_load_skid;

  assign w_accept   = in_valid & r_in_ready & ~flush;
  assign w_out_free = ~r_out_valid | out_ready;

  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_load_out_skid  = 1'b0;
    w_load_out_in    = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      // With SKID full in_ready is low, so an accept cannot collide with the refill.
      if (r_skid_valid) begin
        w_load_out_skid  = 1'b1;
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_load_out_in   = 1'b1;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_load_skid      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_tag    <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tag   <= '0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_load_out_skid) begin
        r_out_imm <= r_skid_imm;
        r_out_tag <= r_skid_tag;
        r_out_err <= r_skid_err;
      end else if (w_load_out_in) begin
        r_out_imm <= w_dec_imm;
        r_out_tag <= in_tag;
        r_out_err <= w_dec_err;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_dec_imm;
        r_skid_tag <= in_tag;
        r_skid_err <= w_dec_err;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_tag   = r_out_tag;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64)
// Both widths see identical stimulus and are scored against one queue model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_src;
  logic [7:0]  in_tag;

  logic        in_ready_a, out_valid_a, out_err_a;
  logic [31:0] out_imm_a;
  logic [7:0]  out_tag_a;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [63:0] out_imm_b;
  logic [7:0]  out_tag_b;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_tag(out_tag_a), .out_err(out_err_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_tag(out_tag_b), .out_err(out_err_b)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          armed = 1'b0;
  bit          hold  = 1'b0;
  logic [31:0] held_imm_a;
  logic [63:0] held_imm_b;
  logic [7:0]  held_tag;
  logic        held_err;

  function automatic exp_t model(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
    exp_t e;
    e.tag = t;
    e.err = 1'b0;
    case (s)
      3'd0: e.imm = {{52{i[31]}}, i[31:20]};
      3'd1: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: e.imm = {{32{i[31]}}, i[31:12], 12'b0};
      3'd4: e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: e.imm = {59'b0, i[19:15]};
      3'd6: e.imm = {52'b0, i[31:20]};
      default: begin
        e.imm = '0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (armed) begin
        chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
        chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
      end
      chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
      chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
      if (hold) begin
        chk("stall_imm_a", 64'(out_imm_a), 64'(held_imm_a));
        chk("stall_imm_b", out_imm_b, held_imm_b);
        chk("stall_tag", 64'(out_tag_a), 64'(held_tag));
        chk("stall_err", 64'(out_err_a), 64'(held_err));
      end
      if (flush) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (out_valid_a && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("imm_a", 64'(out_imm_a), 64'(e.imm[31:0]));
          chk("imm_b", out_imm_b, e.imm);
          chk("tag_a", 64'(out_tag_a), 64'(e.tag));
          chk("tag_b", 64'(out_tag_b), 64'(e.tag));
          chk("err_a", 64'(out_err_a), 64'(e.err));
          chk("err_b", 64'(out_err_b), 64'(e.err));
        end
        if (in_valid && in_ready_a) q.push_back(model(in_instr, in_src, in_tag));
        hold       = out_valid_a && !out_ready;
        held_imm_a = out_imm_a;
        held_imm_b = out_imm_b;
        held_tag   = out_tag_a;
        held_err   = out_err_a;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t,
                          input logic [31:0] exp32, input logic [63:0] exp64, input logic exp_err);
    in_instr  = i;
    in_src    = s;
    in_tag    = t;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("direct_valid", 64'(out_valid_a), 64'd1);
    chk("direct_imm32", 64'(out_imm_a), 64'(exp32));
    chk("direct_imm64", out_imm_b, exp64);
    chk("direct_err", 64'(out_err_b), 64'(exp_err));
    tick();
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_valid"}, 64'({out_valid_a, out_valid_b}), 64'd0);
    chk({name, "_imm"}, out_imm_b | 64'(out_imm_a), 64'd0);
    chk({name, "_tag"}, 64'({out_tag_a, out_tag_b}), 64'd0);
    chk({name, "_err"}, 64'({out_err_a, out_err_b}), 64'd0);
    chk({name, "_in_ready"}, 64'({in_ready_a, in_ready_b}), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_src    = '0;
    in_tag    = '0;

    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 64'({in_ready_a, in_ready_b}), 64'd3);
    armed = 1'b1;

    send_one(32'hFFF00093, 3'd0, 8'h01, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_one(32'hFE000EE3, 3'd2, 8'h02, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_one(32'h0080006F, 3'd4, 8'h03, 32'h00000008, 64'h0000000000000008, 1'b0);
    send_one(32'h800000B7, 3'd3, 8'h04, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    send_one(32'h000F8073, 3'd5, 8'h05, 32'h0000001F, 64'h000000000000001F, 1'b0);
    send_one(32'hFFF00093, 3'd6, 8'h06, 32'h00000FFF, 64'h0000000000000FFF, 1'b0);
    send_one(32'hFE112E23, 3'd1, 8'h07, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_one(32'hFFFFFFFF, 3'd7, 8'h08, 32'h00000000, 64'h0000000000000000, 1'b1);

    out_ready = 1'b0;
    in_src    = 3'd0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_tag = 8'd1; tick();
    in_instr  = 32'h00200093; in_tag = 8'd2; tick();
    in_instr  = 32'h00300093; in_tag = 8'd3; tick();
    chk("stall_head_tag", 64'(out_tag_a), 64'd1);
    chk("stall_in_ready", 64'(in_ready_a), 64'd0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 8'h21; tick();
    in_tag    = 8'h22; tick();
    flush     = 1'b1;
    in_tag    = 8'h55;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    chk("flush_in_ready", 64'({in_ready_a, in_ready_b}), 64'd3);
    out_ready = 1'b1;
    repeat (3) tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 8'h31; tick();
    in_tag    = 8'h32; tick();
    in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    q.delete();
    hold  = 1'b0;
    armed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", 64'({in_ready_a, in_ready_b}), 64'd3);
    armed     = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = $urandom;
      in_src    = 3'($urandom_range(0, 7));
      in_tag    = 8'($urandom_range(0, 255));
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
